pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed decode-to-execute pipeline register.
- One generic stage register for any boundary (F/D, D/E, E/M, M/W), with a valid/ready handshake on both sides and configurable payload width.
- Distinguishes flush (kill the input beat) from bubble (stall upstream and insert a hole downstream). Both keep the PC in the hole so exception/EPC logic sees a meaningful address.
- Sits between two pipeline stages, driven by the hazard unit.

Parameters:
- PC_W, 32, PC width.
- INSTR_W, 32, instruction width.
- PAYLOAD_W, 96, concatenated stage data (ext, RD1, RD2, ...).
- RESET_PC, 32'h8000_0000, PC value loaded at reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage accepts beat this cycle.
- in_instr  input  INSTR_W  upstream instruction.
- in_pc  input  PC_W  upstream PC.
- in_payload  input  PAYLOAD_W  upstream data.
- flush  input  1  kill stage contents and the current input beat.
- bubble  input  1  hold upstream, insert empty slot downstream.
- out_valid  output  1  stage holds a real instruction.
- out_ready  input  1  downstream accepts.
- out_instr  output  INSTR_W  registered instruction.
- out_pc  output  PC_W  registered PC.
- out_pc8  output  PC_W  registered in_pc+8.
- out_payload  output  PAYLOAD_W  registered data.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_instr=0, out_payload=0.
  - out_pc=RESET_PC, out_pc8=RESET_PC.
  - Skid entry (if built) invalid.
  - Reset mid-transfer discards everything; the first edge after deassertion behaves as an empty stage.
- Definitions:
  - slot_free = !out_valid || out_ready.
  - Accept = in_valid && in_ready.
  - Latency input to output: 1 cycle.
- Priority per edge: reset > flush > bubble > normal.
- flush (takes effect regardless of out_ready):
  - out_valid<=0, out_instr<=0, out_payload<=0.
  - out_pc<=in_pc, out_pc8<=in_pc+8.
  - Skid cleared.
  - in_ready=1 during flush; any presented beat is consumed and discarded.
- bubble && !flush:
  - in_ready=0; the upstream beat is held.
  - If slot_free (and skid empty when built): out_valid<=0, out_instr<=0, out_payload<=0, out_pc<=in_pc, out_pc8<=in_pc+8.
  - Otherwise the outputs hold unchanged.
  - bubble is level-sensitive and re-evaluated each cycle.
- Normal:
  - in_ready = slot_free (combinational from out_ready).
  - On Accept, load out_* from in_*; out_valid<=1.
  - On slot_free && !in_valid: out_valid<=0, out_instr<=0; PC and payload hold.
  - On !slot_free: all outputs hold, stable while out_valid && !out_ready.
- out_pc8 arithmetic: modulo 2^PC_W; in_pc = all-ones-minus-3 wraps to 4.
- Invariant: out_* never change while out_valid=1 && out_ready=0, except by flush or reset.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - One-entry skid buffer.
  - in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - A beat accepted while !slot_free goes to the skid.
  - When the output drains, skid moves to the output before any new input.
  - Order is preserved; flush clears the skid; bubble is applied only once the skid is empty.
- Undefined: no skid storage; in_ready is combinational as above.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> out_valid=0, out_pc=32'h80000000, out_pc8=32'h80000000 immediately, before the next edge.
- Pass-through: in_pc=0x80000010, instr=0x24080005, out_ready=1 -> next cycle out_valid=1, out_pc8=0x80000018, payload matches.
- Backpressure: out_ready=0 for 3 cycles with new inputs -> outputs stable. Without skid, in_ready=0. With skid, one beat absorbed, then in_ready=0, and order is preserved on release.
- Bubble: bubble=1, in_pc=0x80000020, out_ready=1 -> in_ready=0, out_valid=0, out_instr=0, out_pc=0x80000020. Upstream beat delivered the cycle after bubble drops.
- Flush vs stall: out_valid=1, out_ready=0, flush=1 -> next cycle out_valid=0, out_pc=in_pc, input beat discarded. Flush together with bubble -> flush behaviour wins.
- Wrap: in_pc=0xFFFFFFFC -> out_pc8=0x00000004.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and bubble insertion.
// Optional one-entry skid buffer when PIPE_STAGE_SKID_EN is defined (registered in_ready).
module pipe_stage_reg #(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     INSTR_W   = 32,
    parameter int unsigned     PAYLOAD_W = 96,
    parameter logic [PC_W-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    input  logic                 bubble,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [PC_W-1:0]      out_pc,
    output logic [PC_W-1:0]      out_pc8,
    output logic [PAYLOAD_W-1:0] out_payload
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(8);

    logic slot_free;
    assign slot_free = !out_valid || out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_valid;
    logic [INSTR_W-1:0]   skid_instr;
    logic [PC_W-1:0]      skid_pc;
    logic [PAYLOAD_W-1:0] skid_payload;

    // Depends only on state and hazard controls, never on out_ready.
    assign in_ready = flush || (!bubble && !skid_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_payload  <= '0;
            out_pc       <= RESET_PC;
            out_pc8      <= RESET_PC;
            skid_valid   <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
            skid_payload <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_payload <= '0;
            out_pc      <= in_pc;
            out_pc8     <= in_pc + PC_STEP;
            skid_valid  <= 1'b0;
        end else if (skid_valid) begin
            // Skid drains ahead of any new beat or bubble; in_ready is low here.
            if (slot_free) begin
                out_valid   <= 1'b1;
                out_instr   <= skid_instr;
                out_payload <= skid_payload;
                out_pc      <= skid_pc;
                out_pc8     <= skid_pc + PC_STEP;
                skid_valid  <= 1'b0;
            end
        end else if (bubble) begin
            if (slot_free) begin
                out_valid   <= 1'b0;
                out_instr   <= '0;
                out_payload <= '0;
                out_pc      <= in_pc;
                out_pc8     <= in_pc + PC_STEP;
            end
        end else if (slot_free) begin
            if (in_valid) begin
                out_valid   <= 1'b1;
                out_instr   <= in_instr;
                out_payload <= in_payload;
                out_pc      <= in_pc;
                out_pc8     <= in_pc + PC_STEP;
            end else begin
                out_valid <= 1'b0;
                out_instr <= '0;
            end
        end else if (in_valid) begin
            skid_valid   <= 1'b1;
            skid_instr   <= in_instr;
            skid_pc      <= in_pc;
            skid_payload <= in_payload;
        end
    end
`else
    assign in_ready = flush || (!bubble && slot_free);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_payload <= '0;
            out_pc      <= RESET_PC;
            out_pc8     <= RESET_PC;
        end else if (flush || (bubble && slot_free)) begin
            // Hole keeps the upstream PC so exception logic sees a real address.
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_payload <= '0;
            out_pc      <= in_pc;
            out_pc8     <= in_pc + PC_STEP;
        end else if (!bubble && slot_free) begin
            if (in_valid) begin
                out_valid   <= 1'b1;
                out_instr   <= in_instr;
                out_payload <= in_payload;
                out_pc      <= in_pc;
                out_pc8     <= in_pc + PC_STEP;
            end else begin
                out_valid <= 1'b0;
                out_instr <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (default build, no skid buffer).
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [95:0] in_payload;
    logic        flush;
    logic        bubble;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;
    logic [95:0] out_payload;

    pipe_stage_reg #(
        .PC_W      (32),
        .INSTR_W   (32),
        .PAYLOAD_W (96),
        .RESET_PC  (32'h8000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_payload  (in_payload),
        .flush       (flush),
        .bubble      (bubble),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc8     (out_pc8),
        .out_payload (out_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: what the downstream stage should be looking at.
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_pc8;
    logic [95:0] m_pay;
    int          delivered_beats = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = '0;
        m_pc    = 32'h8000_0000;
        m_pc8   = 32'h8000_0000;
        m_pay   = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"},   128'(out_valid),   128'(m_valid));
        chk({tag, ".instr"},   128'(out_instr),   128'(m_instr));
        chk({tag, ".pc"},      128'(out_pc),      128'(m_pc));
        chk({tag, ".pc8"},     128'(out_pc8),     128'(m_pc8));
        chk({tag, ".payload"}, 128'(out_payload), 128'(m_pay));
    endtask

    // One clock: drive, check in_ready before the edge, advance model, check outputs after it.
    task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [95:0] pay,
                        input logic ordy, input logic fl, input logic bb);
        logic        downstream_takes;
        logic        exp_rdy;
        in_valid   = iv;
        in_instr   = ins;
        in_pc      = pc;
        in_payload = pay;
        out_ready  = ordy;
        flush      = fl;
        bubble     = bb;
        #1;
        // The slot can take something if it is empty or its content is being consumed.
        downstream_takes = m_valid && ordy;
        if (fl)      exp_rdy = 1'b1;
        else if (bb) exp_rdy = 1'b0;
        else         exp_rdy = !m_valid || ordy;
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(exp_rdy));
        if (downstream_takes) delivered_beats++;
        if (fl || (bb && (!m_valid || ordy))) begin
            m_valid = 1'b0;
            m_instr = '0;
            m_pay   = '0;
            m_pc    = pc;
            m_pc8   = pc + 32'd8;
        end else if (!bb && (!m_valid || ordy)) begin
            if (iv) begin
                m_valid = 1'b1;
                m_instr = ins;
                m_pay   = pay;
                m_pc    = pc;
                m_pc8   = pc + 32'd8;
            end else begin
                m_valid = 1'b0;
                m_instr = '0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [95:0] p;
        logic [31:0] rpc;
        reset = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; in_payload = '0;
        flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        check_outputs("reset_init");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Pass-through
        p = rnd96();
        step("pass", 1'b1, 32'h2408_0005, 32'h8000_0010, p, 1'b1, 1'b0, 1'b0);
        chk("pass.pc8_lit", 128'(out_pc8), 128'(32'h8000_0018));

        // Backpressure: held beat stays put while new beats are offered
        step("bp_load", 1'b1, 32'h1111_1111, 32'h8000_0014, rnd96(), 1'b0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 3; i++)
            step("bp_hold", 1'b1, $urandom, 32'h8000_0100 + 32'(i * 4), rnd96(), 1'b0, 1'b0, 1'b0);
        step("bp_release", 1'b1, 32'h2222_2222, 32'h8000_0018, rnd96(), 1'b1, 1'b0, 1'b0);

        // Bubble: hole downstream, upstream beat held then delivered
        p = rnd96();
        step("bubble", 1'b1, 32'h3333_3333, 32'h8000_0020, p, 1'b1, 1'b0, 1'b1);
        chk("bubble.pc_lit", 128'(out_pc), 128'(32'h8000_0020));
        step("bubble_rel", 1'b1, 32'h3333_3333, 32'h8000_0020, p, 1'b1, 1'b0, 1'b0);
        // Bubble against a stalled full stage holds outputs
        step("bubble_stall", 1'b1, 32'h4444_4444, 32'h8000_0024, rnd96(), 1'b0, 1'b0, 1'b1);

        // Flush wins over a stall, and over a bubble
        step("flush_stall", 1'b1, 32'h5555_5555, 32'h8000_0030, rnd96(), 1'b0, 1'b1, 1'b0);
        chk("flush_stall.pc_lit", 128'(out_pc), 128'(32'h8000_0030));
        step("refill", 1'b1, 32'h6666_6666, 32'h8000_0034, rnd96(), 1'b0, 1'b0, 1'b0);
        step("flush_bubble", 1'b1, 32'h7777_7777, 32'h8000_0040, rnd96(), 1'b0, 1'b1, 1'b1);
        step("idle", 1'b0, 32'h0, 32'h8000_0044, rnd96(), 1'b1, 1'b0, 1'b0);

        // PC+8 wrap
        step("wrap", 1'b1, 32'h0000_0013, 32'hFFFF_FFFC, rnd96(), 1'b1, 1'b0, 1'b0);
        chk("wrap.pc8_lit", 128'(out_pc8), 128'(32'h0000_0004));
        step("wrap_flush", 1'b1, 32'h0000_0013, 32'hFFFF_FFF8, rnd96(), 1'b1, 1'b1, 1'b0);

        // Randomised traffic
        for (int unsigned i = 0; i < 400; i++) begin
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                               : {$urandom, 2'b00};
            step("rand", $urandom_range(0, 3) != 0, $urandom, rpc, rnd96(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset mid-cycle with a beat held
        step("pre_reset", 1'b1, 32'h8888_8888, 32'h8000_0050, rnd96(), 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        step("post_reset_empty", 1'b0, 32'h9999_9999, 32'h8000_0060, rnd96(), 1'b0, 1'b0, 1'b0);
        step("post_reset_load", 1'b1, 32'hAAAA_AAAA, 32'h8000_0064, rnd96(), 1'b1, 1'b0, 1'b0);

        chk("beats_seen", 128'(delivered_beats > 0), 128'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
